// File: rtl/adc_buffer_ctrl.sv
// rtl/adc_buffer_ctrl.sv - dual-channel ADC sample pairing into two RAM ring buffers
module adc_buffer_ctrl #(
    parameter int                       DATA_WIDTH    = 32,
    parameter int                       ADDRESS_WIDTH = 12,
    parameter int                       SAMPLE_WIDTH  = 12,
    parameter int                       BUF_LOG2      = 10,
    parameter logic [ADDRESS_WIDTH-1:0] EMG_BASE      = 12'h800,
    parameter logic [ADDRESS_WIDTH-1:0] ECG_BASE      = 12'hC00
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic                     emg_valid,
    input  logic [SAMPLE_WIDTH-1:0]  emg_data,
    input  logic                     ecg_valid,
    input  logic [SAMPLE_WIDTH-1:0]  ecg_data,
    output logic                     emg_ready,
    output logic                     ecg_ready,
    input  logic                     cpu_wEn,
    input  logic [ADDRESS_WIDTH-1:0] cpu_addr,
    output logic                     adc_wEn,
    output logic [ADDRESS_WIDTH-1:0] adc_addr_emg,
    output logic [ADDRESS_WIDTH-1:0] adc_addr_ecg,
    output logic [DATA_WIDTH-1:0]    adc_dataIn_emg,
    output logic [DATA_WIDTH-1:0]    adc_dataIn_ecg,
    output logic [BUF_LOG2-1:0]      wr_idx,
    output logic                     half_pulse,
    output logic                     wrap_pulse,
    output logic [15:0]              wrap_cnt,
    output logic                     overrun,
    output logic [7:0]               drop_cnt,
    input  logic                     clr_status
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COLLECT = 2'd1;
    localparam logic [1:0] S_WRITE   = 2'd2;

    localparam logic [BUF_LOG2-1:0] HALF_IDX = {1'b1, {(BUF_LOG2-1){1'b0}}};
    localparam logic [BUF_LOG2-1:0] LAST_IDX = '1;

    logic [1:0]              state_q, state_d;
    logic                    emg_full_q, emg_full_d;
    logic                    ecg_full_q, ecg_full_d;
    logic [SAMPLE_WIDTH-1:0] emg_hold_q, emg_hold_d;
    logic [SAMPLE_WIDTH-1:0] ecg_hold_q, ecg_hold_d;
    logic [BUF_LOG2-1:0]     wr_idx_q, wr_idx_d;
    logic [15:0]             wrap_cnt_q, wrap_cnt_d;
    logic                    half_q, half_d;
    logic                    wrap_q, wrap_d;
    logic                    overrun_q, overrun_d;
    logic [7:0]              drop_cnt_q, drop_cnt_d;

    logic                    emg_take, ecg_take;
    logic                    drop_emg, drop_ecg;
    logic [1:0]              drop_n;
    logic [8:0]              drop_sum;
    logic                    conflict;
    logic                    write_fire;

    // Outputs are forced to their idle values while reset is asserted so that
    // no strobe or stale address escapes before the first reset edge lands.
    always_comb begin
        emg_ready      = rst_n & (state_q == S_COLLECT) & ~emg_full_q;
        ecg_ready      = rst_n & (state_q == S_COLLECT) & ~ecg_full_q;
        adc_addr_emg   = rst_n ? (EMG_BASE + ADDRESS_WIDTH'(wr_idx_q)) : EMG_BASE;
        adc_addr_ecg   = rst_n ? (ECG_BASE + ADDRESS_WIDTH'(wr_idx_q)) : ECG_BASE;
        adc_dataIn_emg = DATA_WIDTH'(emg_hold_q);
        adc_dataIn_ecg = DATA_WIDTH'(ecg_hold_q);
        conflict       = cpu_wEn & ((cpu_addr == adc_addr_emg) | (cpu_addr == adc_addr_ecg));
        write_fire     = rst_n & (state_q == S_WRITE) & ~conflict;
        adc_wEn        = write_fire;
        wr_idx         = wr_idx_q;
        half_pulse     = rst_n & half_q;
        wrap_pulse     = rst_n & wrap_q;
        wrap_cnt       = wrap_cnt_q;
        overrun        = overrun_q;
        drop_cnt       = drop_cnt_q;
        emg_take       = emg_valid & emg_ready;
        ecg_take       = ecg_valid & ecg_ready;
        drop_emg       = enable & emg_valid & ~emg_ready;
        drop_ecg       = enable & ecg_valid & ~ecg_ready;
        drop_n         = 2'(drop_emg) + 2'(drop_ecg);
        drop_sum       = {1'b0, drop_cnt_q} + {7'b0, drop_n};
    end

    // FSM, sample capture and ring-index progression.
    always_comb begin
        state_d    = state_q;
        emg_full_d = emg_full_q;
        ecg_full_d = ecg_full_q;
        emg_hold_d = emg_hold_q;
        ecg_hold_d = ecg_hold_q;
        wr_idx_d   = wr_idx_q;
        wrap_cnt_d = wrap_cnt_q;
        half_d     = 1'b0;
        wrap_d     = 1'b0;

        if (emg_take) begin
            emg_hold_d = emg_data;
            emg_full_d = 1'b1;
        end
        if (ecg_take) begin
            ecg_hold_d = ecg_data;
            ecg_full_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (enable) state_d = S_COLLECT;
            end
            S_COLLECT: begin
                if (!enable) begin
                    // Half-collected pairs are discarded; the ring position is kept.
                    state_d    = S_IDLE;
                    emg_full_d = 1'b0;
                    ecg_full_d = 1'b0;
                end else if (emg_full_d && ecg_full_d) begin
                    // Look at the next-state flags so a pair completing this edge
                    // writes in the very next cycle.
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                // A CPU collision simply holds the state; a pending write always
                // completes even after enable drops.
                if (write_fire) begin
                    emg_full_d = 1'b0;
                    ecg_full_d = 1'b0;
                    wr_idx_d   = wr_idx_q + 1'b1;
                    half_d     = (wr_idx_d == HALF_IDX);
                    if (wr_idx_q == LAST_IDX) begin
                        wrap_d     = 1'b1;
                        wrap_cnt_d = wrap_cnt_q + 16'd1;
                    end
                    state_d = enable ? S_COLLECT : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Drop accounting: a same-cycle clear restarts the count from this cycle's drops.
    always_comb begin
        overrun_d  = overrun_q;
        drop_cnt_d = drop_cnt_q;
        if (clr_status) begin
            overrun_d  = (drop_n != 2'd0);
            drop_cnt_d = {6'b0, drop_n};
        end else if (drop_n != 2'd0) begin
            overrun_d  = 1'b1;
            drop_cnt_d = drop_sum[8] ? 8'hFF : drop_sum[7:0];
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            emg_full_q <= 1'b0;
            ecg_full_q <= 1'b0;
            emg_hold_q <= '0;
            ecg_hold_q <= '0;
            wr_idx_q   <= '0;
            wrap_cnt_q <= '0;
            half_q     <= 1'b0;
            wrap_q     <= 1'b0;
            overrun_q  <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            emg_full_q <= emg_full_d;
            ecg_full_q <= ecg_full_d;
            emg_hold_q <= emg_hold_d;
            ecg_hold_q <= ecg_hold_d;
            wr_idx_q   <= wr_idx_d;
            wrap_cnt_q <= wrap_cnt_d;
            half_q     <= half_d;
            wrap_q     <= wrap_d;
            overrun_q  <= overrun_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

endmodule

// File: tb/tb_adc_buffer_ctrl.sv
// tb/tb_adc_buffer_ctrl.sv - scoreboard bench for adc_buffer_ctrl
module tb_adc_buffer_ctrl;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        emg_valid;
    logic [11:0] emg_data;
    logic        ecg_valid;
    logic [11:0] ecg_data;
    logic        emg_ready;
    logic        ecg_ready;
    logic        cpu_wEn;
    logic [11:0] cpu_addr;
    logic        adc_wEn;
    logic [11:0] adc_addr_emg;
    logic [11:0] adc_addr_ecg;
    logic [31:0] adc_dataIn_emg;
    logic [31:0] adc_dataIn_ecg;
    logic [9:0]  wr_idx;
    logic        half_pulse;
    logic        wrap_pulse;
    logic [15:0] wrap_cnt;
    logic        overrun;
    logic [7:0]  drop_cnt;
    logic        clr_status;

    adc_buffer_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .enable         (enable),
        .emg_valid      (emg_valid),
        .emg_data       (emg_data),
        .ecg_valid      (ecg_valid),
        .ecg_data       (ecg_data),
        .emg_ready      (emg_ready),
        .ecg_ready      (ecg_ready),
        .cpu_wEn        (cpu_wEn),
        .cpu_addr       (cpu_addr),
        .adc_wEn        (adc_wEn),
        .adc_addr_emg   (adc_addr_emg),
        .adc_addr_ecg   (adc_addr_ecg),
        .adc_dataIn_emg (adc_dataIn_emg),
        .adc_dataIn_ecg (adc_dataIn_ecg),
        .wr_idx         (wr_idx),
        .half_pulse     (half_pulse),
        .wrap_pulse     (wrap_pulse),
        .wrap_cnt       (wrap_cnt),
        .overrun        (overrun),
        .drop_cnt       (drop_cnt),
        .clr_status     (clr_status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [11:0] ae;
        logic [11:0] ac;
        logic [31:0] de;
        logic [31:0] dc;
    } wr_t;

    wr_t         exp_q[$];
    wr_t         mon_e;
    logic [9:0]  exp_idx;
    int          n_cmp;
    int          n_err;
    int          n_pushed;
    int          n_written;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [11:0] e, input logic [11:0] c);
        exp_q.push_back({12'h800 + {2'b0, exp_idx}, 12'hC00 + {2'b0, exp_idx}, {20'b0, e}, {20'b0, c}});
        n_pushed++;
        exp_idx = exp_idx + 10'd1;
    endtask

    // Offer a simultaneous pair from COLLECT; returns one cycle after the write edge.
    task automatic do_pair(input logic [11:0] e, input logic [11:0] c);
        emg_valid = 1'b1; emg_data = e;
        ecg_valid = 1'b1; ecg_data = c;
        push_exp(e, c);
        tick();
        emg_valid = 1'b0;
        ecg_valid = 1'b0;
        tick();
    endtask

    // Monitor: every RAM write strobe is matched against the oldest expectation.
    always @(negedge clk) begin
        if (adc_wEn === 1'b1) begin
            n_written++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_write: got addr %0h/%0h expected no write", adc_addr_emg, adc_addr_ecg);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wr_addr_emg", {20'b0, adc_addr_emg}, {20'b0, mon_e.ae});
                chk("wr_addr_ecg", {20'b0, adc_addr_ecg}, {20'b0, mon_e.ac});
                chk("wr_data_emg", adc_dataIn_emg, mon_e.de);
                chk("wr_data_ecg", adc_dataIn_ecg, mon_e.dc);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    logic [11:0] stall_ae;
    logic [11:0] stall_ac;

    initial begin
        n_cmp = 0; n_err = 0; n_pushed = 0; n_written = 0;
        exp_idx = 10'd0;
        rst_n = 1'b0; enable = 1'b0;
        emg_valid = 1'b0; emg_data = '0;
        ecg_valid = 1'b0; ecg_data = '0;
        cpu_wEn = 1'b0; cpu_addr = '0; clr_status = 1'b0;

        // Reset state.
        repeat (3) tick();
        @(negedge clk);
        chk("rst_wEn", {31'b0, adc_wEn}, 32'd0);
        chk("rst_emg_ready", {31'b0, emg_ready}, 32'd0);
        chk("rst_ecg_ready", {31'b0, ecg_ready}, 32'd0);
        chk("rst_addr_emg", {20'b0, adc_addr_emg}, 32'h800);
        chk("rst_addr_ecg", {20'b0, adc_addr_ecg}, 32'hC00);
        chk("rst_wr_idx", {22'b0, wr_idx}, 32'd0);
        chk("rst_pulses", {30'b0, half_pulse, wrap_pulse}, 32'd0);
        chk("rst_wrap_cnt", {16'b0, wrap_cnt}, 32'd0);
        chk("rst_drop_cnt", {24'b0, drop_cnt}, 32'd0);
        chk("rst_overrun", {31'b0, overrun}, 32'd0);
        tick();
        rst_n = 1'b1;
        enable = 1'b1;
        tick();

        // Simultaneous pair.
        @(negedge clk);
        chk("collect_ready", {30'b0, emg_ready, ecg_ready}, 32'd3);
        do_pair(12'h123, 12'hABC);
        @(negedge clk);
        chk("pair1_wr_idx", {22'b0, wr_idx}, 32'd1);
        chk("pair1_wEn_off", {31'b0, adc_wEn}, 32'd0);

        // EMG first, ECG five cycles later; extra EMG offers are drops.
        emg_valid = 1'b1; emg_data = 12'h055;
        tick();
        emg_data = 12'h0EE;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("wait_emg_ready", {31'b0, emg_ready}, 32'd0);
            chk("wait_no_wEn", {31'b0, adc_wEn}, 32'd0);
            tick();
        end
        emg_valid = 1'b0;
        ecg_valid = 1'b1; ecg_data = 12'h777;
        push_exp(12'h055, 12'h777);
        @(negedge clk);
        chk("late_emg_ready", {31'b0, emg_ready}, 32'd0);
        chk("late_ecg_ready", {31'b0, ecg_ready}, 32'd1);
        chk("late_no_wEn", {31'b0, adc_wEn}, 32'd0);
        tick();
        ecg_valid = 1'b0;
        tick();
        @(negedge clk);
        chk("drop4_cnt", {24'b0, drop_cnt}, 32'd4);
        chk("drop4_overrun", {31'b0, overrun}, 32'd1);
        clr_status = 1'b1;
        tick();
        clr_status = 1'b0;
        @(negedge clk);
        chk("clr_cnt", {24'b0, drop_cnt}, 32'd0);
        chk("clr_overrun", {31'b0, overrun}, 32'd0);

        // CPU collision on the ECG address stalls the write for three cycles.
        stall_ae = 12'h800 + {2'b0, exp_idx};
        stall_ac = 12'hC00 + {2'b0, exp_idx};
        emg_valid = 1'b1; emg_data = 12'h5A5;
        ecg_valid = 1'b1; ecg_data = 12'hA5A;
        cpu_wEn = 1'b1; cpu_addr = stall_ac;
        push_exp(12'h5A5, 12'hA5A);
        tick();
        emg_valid = 1'b0; ecg_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_wEn", {31'b0, adc_wEn}, 32'd0);
            chk("stall_addr_emg", {20'b0, adc_addr_emg}, {20'b0, stall_ae});
            chk("stall_addr_ecg", {20'b0, adc_addr_ecg}, {20'b0, stall_ac});
            tick();
        end
        cpu_wEn = 1'b0;
        @(negedge clk);
        chk("stall_release_wEn", {31'b0, adc_wEn}, 32'd1);
        tick();

        // Reset during WRITE aborts the write.
        emg_valid = 1'b1; emg_data = 12'h111;
        ecg_valid = 1'b1; ecg_data = 12'h222;
        tick();
        emg_valid = 1'b0; ecg_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        chk("rstw_wEn", {31'b0, adc_wEn}, 32'd0);
        tick();
        rst_n = 1'b1;
        enable = 1'b0;
        exp_idx = 10'd0;
        @(negedge clk);
        chk("rstw_wEn_after", {31'b0, adc_wEn}, 32'd0);
        chk("rstw_ready", {30'b0, emg_ready, ecg_ready}, 32'd0);
        chk("rstw_addr_emg", {20'b0, adc_addr_emg}, 32'h800);
        chk("rstw_addr_ecg", {20'b0, adc_addr_ecg}, 32'hC00);
        chk("rstw_data_emg", adc_dataIn_emg, 32'd0);
        chk("rstw_wr_idx", {22'b0, wr_idx}, 32'd0);
        chk("rstw_wrap_cnt", {16'b0, wrap_cnt}, 32'd0);
        enable = 1'b1;
        tick();

        // Full ring pass: half pulse after pair 512, wrap pulse after pair 1024.
        for (int i = 0; i < 1024; i++) begin
            do_pair(12'(i), 12'(~i));
            @(negedge clk);
            chk("ring_half_pulse", {31'b0, half_pulse}, (i == 511) ? 32'd1 : 32'd0);
            chk("ring_wrap_pulse", {31'b0, wrap_pulse}, (i == 1023) ? 32'd1 : 32'd0);
        end
        chk("ring_wrap_cnt", {16'b0, wrap_cnt}, 32'd1);
        chk("ring_wr_idx", {22'b0, wr_idx}, 32'd0);
        do_pair(12'hFED, 12'h0DE);
        @(negedge clk);
        chk("ring_1025_pulses", {30'b0, half_pulse, wrap_pulse}, 32'd0);

        // 300 double drops while a write is stalled, then clear during a drop.
        stall_ae = 12'h800 + {2'b0, exp_idx};
        emg_valid = 1'b1; emg_data = 12'h321;
        ecg_valid = 1'b1; ecg_data = 12'h654;
        cpu_wEn = 1'b1; cpu_addr = stall_ae;
        push_exp(12'h321, 12'h654);
        tick();
        repeat (127) tick();
        @(negedge clk);
        chk("drop_254", {24'b0, drop_cnt}, 32'd254);
        tick();
        @(negedge clk);
        chk("drop_sat", {24'b0, drop_cnt}, 32'd255);
        repeat (172) tick();
        @(negedge clk);
        chk("drop_sat_300", {24'b0, drop_cnt}, 32'd255);
        chk("drop_sat_overrun", {31'b0, overrun}, 32'd1);
        chk("drop_stall_wEn", {31'b0, adc_wEn}, 32'd0);
        clr_status = 1'b1;
        tick();
        clr_status = 1'b0;
        emg_valid = 1'b0; ecg_valid = 1'b0;
        cpu_wEn = 1'b0;
        @(negedge clk);
        chk("clr_drop_cnt", {24'b0, drop_cnt}, 32'd2);
        chk("clr_drop_overrun", {31'b0, overrun}, 32'd1);
        tick();

        // Enable falling with one sample held discards it and keeps wr_idx.
        emg_valid = 1'b1; emg_data = 12'h3C3;
        tick();
        emg_valid = 1'b0;
        enable = 1'b0;
        tick();
        enable = 1'b1;
        @(negedge clk);
        chk("disc_idle_ready", {30'b0, emg_ready, ecg_ready}, 32'd0);
        chk("disc_wr_idx", {22'b0, wr_idx}, {22'b0, exp_idx});
        tick();
        @(negedge clk);
        chk("disc_ready_back", {30'b0, emg_ready, ecg_ready}, 32'd3);
        do_pair(12'h9A9, 12'h6B6);

        repeat (3) tick();
        chk("queue_drained", exp_q.size(), 32'd0);
        chk("write_count", n_written, n_pushed);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
